instr_mem_loader: RTL

- Writer side of the instruction memory: receives a program image as a byte stream (e.g. from a UART receiver) and writes it word-by-word into the instruction memory write port.
- Holds the CPU pipeline (cpu_hold) while loading.
- Releases the CPU when the image is complete.
- Word addressing matches the fetch side: word index = byte address / 4, little-endian byte order.

---
 rtl/instr_mem_loader_if.sv | 33 +++
 rtl/instr_mem_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader_if
// Brief    : Byte-stream, control and memory-write signals of the loader.
// Revision : 1.0
// ============================================================================
interface instr_mem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    // master: byte source / system controller side
    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, err
    );

    // slave: the loader itself
    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, err
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Brief    : Loads a length-prefixed byte image into instruction memory while
//            holding the CPU. INSTR_LOADER_CHECKSUM_EN adds a trailing XOR byte.
// Revision : 1.0
// ============================================================================
module instr_mem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8        // must equal clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_mem_loader_if.slave bus
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN0 = 3'd1, S_LEN1 = 3'd2,
        S_DATA = 3'd3, S_DONE = 3'd4, S_CSUM = 3'd5
    } state_t;
    localparam state_t C_AFTER_DATA = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN0 = 3'd1, S_LEN1 = 3'd2,
        S_DATA = 3'd3, S_DONE = 3'd4
    } state_t;
    localparam state_t C_AFTER_DATA = S_DONE;
`endif

    localparam logic [16:0]       C_DEPTH = 17'(DEPTH);
    localparam logic [ADDR_W-1:0] C_ONE   = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic              w_busy;
    logic              w_xfer;
    logic              w_launch;
    logic              w_done;
    logic              w_last_byte;
    logic [15:0]       w_len;
    logic              w_len_zero;
    logic              w_len_bad;

    logic [7:0]        r_len_lo;
    logic [ADDR_W-1:0] r_last_idx;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_shift;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [31:0]       r_mem_wdata;
    logic              r_err;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

`ifdef INSTR_LOADER_CHECKSUM_EN
    assign w_busy = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                    (r_state == S_DATA) || (r_state == S_CSUM);
`else
    assign w_busy = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                    (r_state == S_DATA);
`endif

    assign w_xfer      = bus.byte_valid && w_busy;
    assign w_launch    = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_len       = {bus.byte_data, r_len_lo};
    assign w_len_zero  = (w_len == 16'd0);
    assign w_len_bad   = ({1'b0, w_len} > C_DEPTH);
    assign w_last_byte = w_xfer && (r_state == S_DATA) &&
                         (r_byte_cnt == 2'd3) && (r_word_idx == r_last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_LEN0;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) w_next = S_LEN0;
            end
            S_LEN0: begin
                if (w_xfer) w_next = S_LEN1;
            end
            S_LEN1: begin
                if (w_xfer) begin
                    if (w_len_bad)       w_next = S_DONE;
                    else if (w_len_zero) w_next = C_AFTER_DATA;
                    else                 w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_byte) w_next = C_AFTER_DATA;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_xfer) w_next = S_DONE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: length capture, word assembly and the registered write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_lo    <= 8'd0;
            r_last_idx  <= '0;
            r_word_idx  <= '0;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 24'd0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= 32'd0;
            r_err       <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            if (w_launch) begin
                r_word_idx <= '0;
                r_byte_cnt <= 2'd0;
                r_shift    <= 24'd0;
                r_err      <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                r_csum     <= 8'd0;
`endif
            end
            if (w_xfer) begin
                case (r_state)
                    S_LEN0: r_len_lo <= bus.byte_data;
                    S_LEN1: begin
                        // N-1 fits ADDR_W bits for every accepted length
                        r_last_idx <= ADDR_W'(w_len - 16'd1);
                        if (w_len_bad) r_err <= 1'b1;
                    end
                    S_DATA: begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ bus.byte_data;
`endif
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_we    <= 1'b1;
                            r_mem_waddr <= r_word_idx;
                            r_mem_wdata <= {bus.byte_data, r_shift};
                            r_word_idx  <= r_word_idx + C_ONE;
                        end else begin
                            r_shift <= {bus.byte_data, r_shift[23:8]};
                        end
                    end
`ifdef INSTR_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (bus.byte_data != r_csum) r_err <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready = w_busy;
    assign bus.cpu_hold   = w_busy;
    assign bus.done       = w_done;
    assign bus.err        = r_err;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_waddr  = r_mem_waddr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire
